led_pattern_gen: RTL and testbench

- Parametrised LED animation engine driving an N-wide LED bank from the 50 MHz board clock.
- Provides four run-time selectable patterns: water fill/drain, running dot, ping-pong bounce and binary count.
- Step rate is selectable at run time, with pause, LED polarity option and status strobes.
- Sits directly between the board clock and the LED pins; mode, speed and pause inputs are tied to switches or keys (pre-debounced upstream).

---
 rtl/led_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED animation engine: water, running dot, bounce and binary count
// patterns with run-time step rate, pause and polarity control.
module led_pattern_gen #(
  parameter int N_LED          = 8,
  parameter int BASE_DIV       = 25_000_000,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam int CW = $clog2(BASE_DIV);

  localparam logic [1:0] M_WATER  = 2'd0;
  localparam logic [1:0] M_RUN    = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_COUNT  = 2'd3;

  localparam logic [N_LED-1:0] ONES = {N_LED{1'b1}};
  localparam logic [N_LED-1:0] ZERO = {N_LED{1'b0}};
  localparam logic [N_LED-1:0] ONE  = {{(N_LED-1){1'b0}}, 1'b1};

  logic [N_LED-1:0] pat_q, pat_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic [31:0]      period;
  logic             tick;
  logic [CW-1:0]    cnt_nx;
  logic [N_LED-1:0] adv_pat;
  logic             adv_dir;
  logic             adv_wrap;

  function automatic logic [N_LED-1:0] init_pat(
    input logic [1:0] m
  );
    logic [N_LED-1:0] r;
    r = ONES;
    unique case (m)
      M_WATER:  r = ONES;
      M_RUN:    r = ONE;
      M_BOUNCE: r = ONE;
      M_COUNT:  r = ZERO;
      default:  r = ONES;
    endcase
    return r;
  endfunction

  // >= rather than == so a speed-up mid-count fires at once.
  always_comb begin
    period = 32'(BASE_DIV) >> speed;
    tick   = !pause && (32'(cnt_q) >= period - 32'd1);
    if (pause)
      cnt_nx = cnt_q;
    else if (tick)
      cnt_nx = '0;
    else
      cnt_nx = cnt_q + CW'(1);
  end

  always_comb begin
    adv_pat = pat_q;
    adv_dir = dir_q;
    unique case (mode_q)
      M_WATER: begin
        adv_pat = (pat_q == ZERO) ? ONES : (pat_q << 1);
      end
      M_RUN: begin
        adv_pat = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
      end
      M_BOUNCE: begin
        if (!dir_q) begin
          adv_pat = pat_q << 1;
          adv_dir = adv_pat[N_LED-1];
        end else begin
          adv_pat = pat_q >> 1;
          adv_dir = (adv_pat != ONE);
        end
      end
      M_COUNT: begin
        adv_pat = pat_q + ONE;
      end
      default: begin
        adv_pat = pat_q;
      end
    endcase
    adv_wrap = (adv_pat == init_pat(mode_q))
             && !((mode_q == M_BOUNCE) && adv_dir);
  end

  // A mode change reloads the pattern and swallows any tick.
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (mode != mode_q) begin
      mode_d = mode;
      pat_d  = init_pat(mode);
      dir_d  = 1'b0;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_nx;
      if (tick) begin
        pat_d  = adv_pat;
        dir_d  = adv_dir;
        step_d = 1'b1;
        wrap_d = adv_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_WATER;
      pat_q  <= ONES;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign led  = pat_q ^ {N_LED{LED_ACTIVE_LOW}};
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: active-high and active-low
// instances share stimulus; expected {wrap,led} queued per step.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [7:0] led, led_n;
  logic       step, step_n;
  logic       wrap, wrap_n;

  int nvec = 0;
  int nerr = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .N_LED(8), .BASE_DIV(8), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed),
    .pause(pause), .led(led), .step(step), .wrap(wrap)
  );

  led_pattern_gen #(
    .N_LED(8), .BASE_DIV(8), .LED_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed),
    .pause(pause), .led(led_n), .step(step_n), .wrap(wrap_n)
  );

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int budget, output int cyc);
    cyc = 0;
    do begin
      tick1();
      cyc++;
    end while (step !== 1'b1 && cyc < budget);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0;
    tick1();
    tick1();
    rst = 1'b0;
    nvec++;
    if (led !== 8'hFF || step !== 1'b0 || wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset: led=%h step=%b wrap=%b want FF 0 0",
               led, step, wrap);
    end
    nvec++;
    if (led_n !== 8'h00 || step_n !== 1'b0) begin
      nerr++;
      $display("FAIL reset_low: led=%h step=%b want 00 0",
               led_n, step_n);
    end
  endtask

  task automatic test_water();
    logic [7:0] tbl [9];
    logic [8:0] e;
    int cyc;
    tbl = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0,
            8'hC0, 8'h80, 8'h00, 8'hFF};
    for (int i = 0; i < 9; i++)
      sb.push_back({(i == 8), tbl[i]});
    for (int i = 0; i < 9; i++) begin
      wait_step(12, cyc);
      e = sb.pop_front();
      nvec++;
      if (step !== 1'b1 || cyc != 8) begin
        nerr++;
        $display("FAIL water_gap[%0d]: %0d cycles want 8", i, cyc);
      end
      nvec++;
      if ({wrap, led} !== e) begin
        nerr++;
        $display("FAIL water[%0d]: wrap/led=%b/%h want %b/%h",
                 i, wrap, led, e[8], e[7:0]);
      end
      nvec++;
      if ({step_n, wrap_n, led_n} !== {1'b1, e[8], ~e[7:0]}) begin
        nerr++;
        $display("FAIL water_low[%0d]: s/w/led=%b/%b/%h want 1/%b/%h",
                 i, step_n, wrap_n, led_n, e[8], ~e[7:0]);
      end
    end
  endtask

  task automatic test_run();
    logic [8:0] e;
    int cyc;
    mode = 2'd1; speed = 2'd3;
    tick1();
    nvec++;
    if (led !== 8'h01 || step !== 1'b0) begin
      nerr++;
      $display("FAIL run_load: led=%h step=%b want 01 0", led, step);
    end
    for (int i = 1; i <= 8; i++)
      sb.push_back({(i == 8), 8'(9'd1 << (i % 8))});
    for (int i = 0; i < 8; i++) begin
      wait_step(4, cyc);
      e = sb.pop_front();
      nvec++;
      if (step !== 1'b1 || cyc != 1 || {wrap, led} !== e) begin
        nerr++;
        $display("FAIL run[%0d]: cyc=%0d w/led=%b/%h want 1 %b/%h",
                 i, cyc, wrap, led, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] e;
    int cyc;
    mode = 2'd2; speed = 2'd1;
    tick1();
    nvec++;
    if (led !== 8'h01 || step !== 1'b0) begin
      nerr++;
      $display("FAIL bounce_load: led=%h step=%b want 01 0", led, step);
    end
    for (int i = 1; i <= 7; i++)
      sb.push_back({1'b0, 8'(9'd1 << i)});
    for (int i = 6; i >= 0; i--)
      sb.push_back({(i == 0), 8'(9'd1 << i)});
    sb.push_back({1'b0, 8'h02});
    for (int i = 0; i < 15; i++) begin
      wait_step(8, cyc);
      e = sb.pop_front();
      nvec++;
      if (step !== 1'b1 || cyc != 4 || {wrap, led} !== e) begin
        nerr++;
        $display("FAIL bounce[%0d]: cyc=%0d w/led=%b/%h want 4 %b/%h",
                 i, cyc, wrap, led, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_count_pause();
    logic [8:0] e;
    int cyc;
    int bad;
    mode = 2'd3; speed = 2'd2;
    tick1();
    nvec++;
    if (led !== 8'h00) begin
      nerr++;
      $display("FAIL count_load: led=%h want 00", led);
    end
    for (int k = 1; k <= 300; k++)
      sb.push_back({(k == 256), 8'(k)});
    for (int k = 1; k <= 300; k++) begin
      wait_step(6, cyc);
      e = sb.pop_front();
      nvec++;
      if (step !== 1'b1 || cyc != ((k == 151) ? 1 : 2)
          || {wrap, led} !== e) begin
        nerr++;
        $display("FAIL count[%0d]: cyc=%0d w/led=%b/%h want %b/%h",
                 k, cyc, wrap, led, e[8], e[7:0]);
      end
      if (k == 150) begin
        tick1();
        pause = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          tick1();
          if (step !== 1'b0 || led !== 8'h96) bad++;
        end
        pause = 1'b0;
        nvec++;
        if (bad != 0) begin
          nerr++;
          $display("FAIL pause_hold: %0d bad cycles want 0", bad);
        end
      end
    end
    nvec++;
    if (led !== 8'h2C) begin
      nerr++;
      $display("FAIL count_final: led=%h want 2C", led);
    end
  endtask

  task automatic test_speed_up();
    int cyc;
    mode = 2'd0; speed = 2'd0;
    tick1();
    for (int c = 0; c < 5; c++) tick1();
    speed = 2'd2;
    wait_step(4, cyc);
    nvec++;
    if (step !== 1'b1 || cyc != 1 || led !== 8'hFE) begin
      nerr++;
      $display("FAIL speed_up: cyc=%0d led=%h want 1 FE", cyc, led);
    end
    wait_step(4, cyc);
    nvec++;
    if (step !== 1'b1 || cyc != 2 || led !== 8'hFC) begin
      nerr++;
      $display("FAIL speed_next: cyc=%0d led=%h want 2 FC", cyc, led);
    end
  endtask

  task automatic test_mode_change_rst();
    logic [8:0] e;
    int cyc;
    int bad;
    mode = 2'd3; speed = 2'd0;
    tick1();
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      tick1();
      if (step !== 1'b0) bad++;
    end
    mode = 2'd1;
    tick1();
    nvec++;
    if (bad != 0 || step !== 1'b0 || led !== 8'h01) begin
      nerr++;
      $display("FAIL chg_due: bad=%0d step=%b led=%h want 0 0 01",
               bad, step, led);
    end
    sb.push_back({1'b0, 8'h02});
    wait_step(12, cyc);
    e = sb.pop_front();
    nvec++;
    if (step !== 1'b1 || cyc != 8 || {wrap, led} !== e) begin
      nerr++;
      $display("FAIL chg_first: cyc=%0d led=%h want 8 %h",
               cyc, led, e[7:0]);
    end
    for (int c = 0; c < 5; c++) tick1();
    rst = 1'b1; mode = 2'd0;
    tick1();
    rst = 1'b0;
    nvec++;
    if (led !== 8'hFF || step !== 1'b0 || led_n !== 8'h00) begin
      nerr++;
      $display("FAIL mid_rst: led=%h step=%b led_n=%h want FF 0 00",
               led, step, led_n);
    end
    wait_step(12, cyc);
    nvec++;
    if (step !== 1'b1 || cyc != 8 || led !== 8'hFE) begin
      nerr++;
      $display("FAIL rst_first: cyc=%0d led=%h want 8 FE", cyc, led);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0;
    test_reset();
    test_water();
    test_run();
    test_bounce();
    test_count_pause();
    test_speed_up();
    test_mode_change_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
